// File: rtl/id_inst_buffer_if.sv
// IF->ID instruction buffer interface: fetch-side push, decode-side pop, EX hazard hints.
interface id_inst_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              ex_is_load;
  logic              ex_we;
  logic [4:0]        ex_waddr;
  logic              stallreq;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready, ex_is_load, ex_we, ex_waddr,
    input  in_ready, out_valid, out_pc, out_inst, stallreq, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready, ex_is_load, ex_we, ex_waddr,
    output in_ready, out_valid, out_pc, out_inst, stallreq, count
  );
endinterface

// File: rtl/id_inst_buffer.sv
// Circular FIFO between fetch and decode with load-use interlock on the head entry
// and flush-on-redirect.
module id_inst_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  id_inst_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  entry_t             head;
  logic               empty;
  logic               hazard;
  logic               ready;
  logic               valid;
  logic               push;
  logic               pop;

  // Head is masked to zero when empty so stale storage never leaks out.
  always_comb begin
    empty  = (cnt == '0);
    head   = empty ? '0 : mem[rd_ptr];
    hazard = !empty && bus.ex_is_load && bus.ex_we && (bus.ex_waddr != 5'd0) &&
             ((head.inst[25:21] == bus.ex_waddr) || (head.inst[20:16] == bus.ex_waddr));
    ready  = (cnt < CNT_W'(DEPTH)) && !bus.flush && !rst;
    valid  = !empty && !hazard && !bus.flush;
    push   = bus.in_valid && ready;
    pop    = valid && bus.out_ready;
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.stallreq  = hazard;
  assign bus.out_pc    = head.pc;
  assign bus.out_inst  = head.inst;
  assign bus.count     = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: bus.in_pc, inst: bus.in_inst};
  end
endmodule

// File: tb/tb_id_inst_buffer.sv
// Bench for id_inst_buffer: directed scenarios plus random traffic against a queue model.
module tb_id_inst_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  ent_t q[$];

  id_inst_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus ();

  id_inst_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl,
                       input logic ld, input logic we, input logic [4:0] wa);
    bus.in_valid   = v;
    bus.in_pc      = pc;
    bus.in_inst    = inst;
    bus.out_ready  = ordy;
    bus.flush      = fl;
    bus.ex_is_load = ld;
    bus.ex_we      = we;
    bus.ex_waddr   = wa;
  endtask

  // One clock: check combinational outputs against the model, step model at the edge.
  task automatic cycle();
    int          n;
    logic        haz;
    logic        e_ready;
    logic        e_valid;
    logic        do_push;
    logic        do_pop;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    ent_t        e;
    #1;
    n      = q.size();
    e_pc   = (n != 0) ? q[0].pc   : 32'd0;
    e_inst = (n != 0) ? q[0].inst : 32'd0;
    haz    = (n != 0) && bus.ex_is_load && bus.ex_we && (bus.ex_waddr != 5'd0) &&
             ((e_inst[25:21] == bus.ex_waddr) || (e_inst[20:16] == bus.ex_waddr));
    e_ready = (n < DEPTH) && !bus.flush && !rst;
    e_valid = (n != 0) && !haz && !bus.flush;
    check("in_ready",  64'(bus.in_ready),  64'(e_ready));
    check("out_valid", 64'(bus.out_valid), 64'(e_valid));
    check("stallreq",  64'(bus.stallreq),  64'(haz));
    check("out_pc",    64'(bus.out_pc),    64'(e_pc));
    check("out_inst",  64'(bus.out_inst),  64'(e_inst));
    check("count",     64'(bus.count),     64'(n));
    do_push = bus.in_valid && e_ready;
    do_pop  = e_valid && bus.out_ready;
    e.pc    = bus.in_pc;
    e.inst  = bus.in_inst;
    @(posedge clk);
    if (bus.flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    #1;
    check("count_post", 64'(bus.count), 64'(q.size()));
  endtask

  logic [31:0] r_inst;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #2;
    check("rst_count",    64'(bus.count),     64'd0);
    check("rst_in_ready", 64'(bus.in_ready),  64'd0);
    check("rst_valid",    64'(bus.out_valid), 64'd0);
    check("rst_out_pc",   64'(bus.out_pc),    64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill then drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h0000_0020 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      cycle();
    end
    drive(1'b1, 32'h999, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    check("full_count", 64'(bus.count),    64'd4);
    check("full_ready", 64'(bus.in_ready), 64'd0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      check("drain_pc", 64'(bus.out_pc), 64'(32'h100 + 32'(4 * i)));
      cycle();
    end
    check("drain_empty", 64'(bus.count), 64'd0);
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Load-use interlock on addu $2,$4,$5
    drive(1'b1, 32'h200, 32'h0085_1021, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    #1;
    check("no_bypass_valid", 64'(bus.out_valid), 64'd0);
    cycle();
    drive(1'b1, 32'h204, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5);
    #1;
    check("lu_stall",  64'(bus.stallreq),  64'd1);
    check("lu_valid",  64'(bus.out_valid), 64'd0);
    check("lu_hold",   64'(bus.out_pc),    64'h200);
    cycle();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    cycle();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);
    #1;
    check("lu_zero_stall", 64'(bus.stallreq), 64'd0);
    check("lu_zero_pc",    64'(bus.out_pc),    64'h200);
    cycle();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle();

    // Flush beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hDEAD0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
      cycle();
    end
    check("flush_count", 64'(bus.count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      check("flush_no_leak", 64'(bus.out_pc == 32'hDEAD0), 64'd0);
      cycle();
    end

    // Steady push+pop at count 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h308 + 32'(4 * i), 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
      #1;
      check("wrap_pc", 64'(bus.out_pc), 64'(32'h300 + 32'(4 * i)));
      cycle();
      check("wrap_count", 64'(bus.count), 64'd2);
    end

    // Asynchronous reset between edges with count 3
    drive(1'b1, 32'h500, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle();
    check("pre_rst_count", 64'(bus.count), 64'd3);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(bus.count),     64'd0);
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_pc",    64'(bus.out_pc),    64'd0);
    check("arst_ready", 64'(bus.in_ready),  64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 32'h600, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    cycle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r_inst = $urandom;
      r_inst[25:21] = 5'($urandom_range(0, 6));
      r_inst[20:16] = 5'($urandom_range(0, 6));
      drive(1'($urandom_range(0, 1)), $urandom, r_inst,
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 6)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_inst_buffer.md
ID_INST_BUFFER -- requirements
Module: id_inst_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-002 Parameter PC_W, default 32, PC field width.
REQ-003 Parameter INST_W, default 32, instruction word width; at least 26 so the rs and rt fields exist.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port flush  input  1  branch-taken redirect; discards all queued entries.
REQ-007 Port in_valid  input  1  IF presents a valid {in_pc, in_inst} pair.
REQ-008 Port in_ready  output  1  buffer accepts a pair this cycle.
REQ-009 Port in_pc  input  PC_W  PC of the incoming instruction.
REQ-010 Port in_inst  input  INST_W  incoming instruction word.
REQ-011 Port out_valid  output  1  head entry is issuable to decode.
REQ-012 Port out_ready  input  1  decode consumes the head entry.
REQ-013 Port out_pc  output  PC_W  PC of the head entry.
REQ-014 Port out_inst  output  INST_W  instruction word of the head entry.
REQ-015 Port ex_is_load  input  1  the instruction in EX is a load.
REQ-016 Port ex_we  input  1  the instruction in EX writes the regfile.
REQ-017 Port ex_waddr  input  5  regfile destination of the instruction in EX.
REQ-018 Port stallreq  output  1  load-use interlock is active on the head entry.
REQ-019 Port count  output  clog2(DEPTH+1)  current number of occupied entries.

Function
REQ-020 Storage: DEPTH-entry circular FIFO of {pc, inst}; wr_ptr and rd_ptr wrap modulo DEPTH; strict FIFO order.
REQ-021 Push condition: in_valid && in_ready; the pair is written at wr_ptr, wr_ptr advances by 1, count increases by 1.
REQ-022 in_ready = (count < DEPTH) && !flush; combinational.
REQ-023 Hazard condition: count != 0 && ex_is_load && ex_we && ex_waddr != 0 && (head inst[25:21] == ex_waddr || head inst[20:16] == ex_waddr).
REQ-024 stallreq = hazard; combinational, same cycle.
REQ-025 out_valid = (count != 0) && !hazard && !flush.
REQ-026 Pop condition: out_valid && out_ready; rd_ptr advances by 1, count decreases by 1.
REQ-027 Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
REQ-028 Latency: a pushed entry appears at out_pc/out_inst no earlier than the next cycle; there is no same-cycle bypass, including when the queue is empty.
REQ-029 out_pc/out_inst show the head entry whenever count != 0, including while hazard is active, and are 0 when count == 0.
REQ-030 Full (count == DEPTH): in_ready = 0; in_valid is ignored and no state changes.
REQ-031 Empty (count == 0): out_valid = 0; out_ready is ignored.
REQ-032 While hazard is active, the head entry is held unchanged and pushes continue while count < DEPTH.
REQ-033 Flush: at the next edge count = 0, wr_ptr = rd_ptr = 0, and all entries are invalid; flush wins over a same-cycle push or pop, neither of which takes effect.
REQ-034 Flush asserted for multiple cycles keeps the queue empty and in_ready = 0 throughout.
REQ-035 count never exceeds DEPTH and never underflows.

Reset
REQ-036 rst = 1 immediately, without waiting for clk, forces count = 0, wr_ptr = rd_ptr = 0, out_valid = 0, stallreq = 0, out_pc = 0 and out_inst = 0.
REQ-037 With rst = 1, in_ready = 0.
REQ-038 Reset asserted mid-operation discards all queued entries; after release, in_ready = 1 at the first edge.
REQ-039 Entry storage contents after reset are don't-care but are never visible on the outputs.

Verification
REQ-040 Fill and drain, DEPTH = 4: push PCs 0x100, 0x104, 0x108, 0x10C with out_ready = 0 -> count = 4 and in_ready = 0; then out_ready = 1 -> out_pc is 0x100, 0x104, 0x108, 0x10C in that order, then count = 0 and out_valid = 0.
REQ-041 Load-use interlock: head inst = 0x00851021 (addu $2, $4, $5); ex_is_load = 1, ex_we = 1, ex_waddr = 5 -> stallreq = 1, out_valid = 0, head held; ex_waddr = 0 -> no stall.
REQ-042 Flush priority: count = 3 with push and pop in the same cycle as flush = 1 -> next cycle count = 0, out_valid = 0, and the pushed PC never appears at the output.
REQ-043 Wrap-around: push and pop steadily for 10 cycles with count held at 2 -> pointers wrap, order is preserved, and count stays 2.
REQ-044 Asynchronous reset: assert rst between clock edges while count = 3 -> count = 0 and out_valid = 0 before the next rising edge.
